// File: rtl/guvm_wb_stim_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : guvm_wb_stim_slave                                           |
// | Description : Wishbone classic slave that stimulates a GUVM core.          |
// |               Reads are served from an instruction FIFO that the bench     |
// |               fills. The instruction is placed in the addressed 32-bit     |
// |               lane and every other lane is padded with NOP_WORD. Writes    |
// |               are captured into a result FIFO for a monitor to drain.      |
// |               Each transfer can be given programmable wait states, and     |
// |               any transfer can be answered with an error instead of ack.   |
// | Ports       : clk, rst                 clock / sync active-high reset      |
// |               inst_valid/data/ready    instruction push interface          |
// |               wait_cycles, err_inject  per-request response shaping        |
// |               wb_*                     Wishbone classic slave port         |
// |               res_valid/ready/data/adr/sel  result FIFO head + pop         |
// |               inst_level, starve_cnt, res_overflow  status                 |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module guvm_wb_stim_slave #(
   parameter int          DATA_W     = 128,
   parameter int          ADDR_W     = 32,
   parameter int          INST_DEPTH = 8,
   parameter int          RES_DEPTH  = 8,
   parameter logic [31:0] NOP_WORD   = 32'hF0801003
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        inst_valid,
   input  logic [31:0]                 inst_data,
   output logic                        inst_ready,
   input  logic [3:0]                  wait_cycles,
   input  logic                        err_inject,
   input  logic [ADDR_W-1:0]           wb_adr,
   input  logic [DATA_W/8-1:0]         wb_sel,
   input  logic                        wb_we,
   input  logic [DATA_W-1:0]           wb_dat_w,
   input  logic                        wb_cyc,
   input  logic                        wb_stb,
   output logic [DATA_W-1:0]           wb_dat_r,
   output logic                        wb_ack,
   output logic                        wb_err,
   output logic                        res_valid,
   input  logic                        res_ready,
   output logic [DATA_W-1:0]           res_data,
   output logic [ADDR_W-1:0]           res_adr,
   output logic [DATA_W/8-1:0]         res_sel,
   output logic [$clog2(INST_DEPTH):0] inst_level,
   output logic [15:0]                 starve_cnt,
   output logic                        res_overflow
);

   localparam int c_LANES  = DATA_W / 32;
   localparam int c_LANE_W = (c_LANES > 1) ? $clog2(c_LANES) : 1;
   localparam int c_IA_W   = $clog2(INST_DEPTH);
   localparam int c_RA_W   = $clog2(RES_DEPTH);
   localparam int c_SEL_W  = DATA_W / 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // ---------------------------------------------------------------- FSM state
   state_t              r_state;
   state_t              w_state_nxt;
   logic [3:0]          r_cnt;
   logic [3:0]          w_cnt_nxt;
   logic                w_accept;
   logic                w_resp;

   // Request captured in IDLE; everything downstream works off these copies.
   logic [ADDR_W-1:0]   r_adr;
   logic                r_we;
   logic [c_SEL_W-1:0]  r_sel;
   logic [DATA_W-1:0]   r_dat_w;
   logic                r_err;

   logic                w_rd_resp;
   logic                w_wr_resp;
   logic [c_LANE_W-1:0] w_lane;
   logic [DATA_W-1:0]   w_rd_data;
   logic [DATA_W-1:0]   r_dat_hold;

   // ------------------------------------------------------- instruction FIFO
   logic [31:0]         r_inst_mem [INST_DEPTH];
   logic [c_IA_W:0]     r_inst_wp;
   logic [c_IA_W:0]     r_inst_rp;
   logic [c_IA_W:0]     w_inst_lvl;
   logic                w_inst_empty;
   logic                w_inst_full;
   logic                w_inst_push;
   logic                w_inst_pop;

   // ------------------------------------------------------------ result FIFO
   logic [ADDR_W-1:0]   r_res_adr_mem [RES_DEPTH];
   logic [c_SEL_W-1:0]  r_res_sel_mem [RES_DEPTH];
   logic [DATA_W-1:0]   r_res_dat_mem [RES_DEPTH];
   logic [c_RA_W:0]     r_res_wp;
   logic [c_RA_W:0]     r_res_rp;
   logic [c_RA_W:0]     w_res_lvl;
   logic                w_res_empty;
   logic                w_res_full;
   logic                w_res_push;
   logic                w_res_pop;
   logic                w_res_drop;

   logic [15:0]         r_starve;
   logic                r_overflow;

   // --------------------------------------------------------- state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // ------------------------------------------------ next state / strobes
   // The response strobe is masked by rst so a reset landing on the
   // response cycle abandons the transfer without ack, err, pop or push.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      w_resp      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (wb_cyc && wb_stb) begin
               w_accept  = 1'b1;
               w_cnt_nxt = wait_cycles;
               w_state_nxt = (wait_cycles == 4'd0) ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!wb_cyc) begin
               w_state_nxt = ST_IDLE;
            end else if (r_cnt == 4'd1) begin
               w_state_nxt = ST_RESP;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         ST_RESP: begin
            w_resp      = !rst;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------- request latch
   always_ff @(posedge clk) begin
      if (rst) begin
         r_adr   <= '0;
         r_we    <= 1'b0;
         r_sel   <= '0;
         r_dat_w <= '0;
         r_err   <= 1'b0;
      end else if (w_accept) begin
         r_adr   <= wb_adr;
         r_we    <= wb_we;
         r_sel   <= wb_sel;
         r_dat_w <= wb_dat_w;
         r_err   <= err_inject;
      end
   end

   assign w_rd_resp = w_resp && !r_we && !r_err;
   assign w_wr_resp = w_resp &&  r_we && !r_err;
   assign wb_ack    = w_resp && !r_err;
   assign wb_err    = w_resp &&  r_err;

   // ------------------------------------------------------------ lane select
   generate
      if (c_LANES > 1) begin : g_lane_multi
         assign w_lane = r_adr[c_LANE_W+1:2];
      end else begin : g_lane_single
         assign w_lane = '0;
      end
   endgenerate

   // Empty is judged on the pointers before this cycle's push, so a word
   // pushed during a starved read is kept for the next read.
   always_comb begin
      w_rd_data = '0;
      for (int i = 0; i < c_LANES; i++) begin
         if (!w_inst_empty && (w_lane == c_LANE_W'(i))) begin
            w_rd_data[i*32 +: 32] = r_inst_mem[r_inst_rp[c_IA_W-1:0]];
         end else begin
            w_rd_data[i*32 +: 32] = NOP_WORD;
         end
      end
   end

   // Read data is driven live during a read response and held afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dat_hold <= '0;
      end else if (w_rd_resp) begin
         r_dat_hold <= w_rd_data;
      end
   end

   assign wb_dat_r = w_rd_resp ? w_rd_data : r_dat_hold;

   // ------------------------------------------------------- instruction FIFO
   assign w_inst_lvl   = r_inst_wp - r_inst_rp;
   assign w_inst_empty = (w_inst_lvl == '0);
   assign w_inst_full  = (w_inst_lvl == (c_IA_W+1)'(INST_DEPTH));
   // Derived from pointer registers only, so no path from the pop side.
   assign inst_ready   = !w_inst_full;
   assign inst_level   = w_inst_lvl;
   assign w_inst_push  = inst_valid && inst_ready;
   assign w_inst_pop   = w_rd_resp && !w_inst_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_inst_wp <= '0;
         r_inst_rp <= '0;
      end else begin
         if (w_inst_push) r_inst_wp <= r_inst_wp + 1'b1;
         if (w_inst_pop)  r_inst_rp <= r_inst_rp + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_inst_push) begin
         r_inst_mem[r_inst_wp[c_IA_W-1:0]] <= inst_data;
      end
   end

   // ------------------------------------------------------------ result FIFO
   assign w_res_lvl   = r_res_wp - r_res_rp;
   assign w_res_empty = (w_res_lvl == '0);
   assign w_res_full  = (w_res_lvl == (c_RA_W+1)'(RES_DEPTH));
   assign res_valid   = !w_res_empty;
   assign w_res_pop   = res_valid && res_ready;
   // A simultaneous pop frees the slot, so a full FIFO still takes the write.
   assign w_res_push  = w_wr_resp && (!w_res_full || w_res_pop);
   assign w_res_drop  = w_wr_resp &&   w_res_full && !w_res_pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_res_wp <= '0;
         r_res_rp <= '0;
      end else begin
         if (w_res_push) r_res_wp <= r_res_wp + 1'b1;
         if (w_res_pop)  r_res_rp <= r_res_rp + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_res_push) begin
         r_res_adr_mem[r_res_wp[c_RA_W-1:0]] <= r_adr;
         r_res_sel_mem[r_res_wp[c_RA_W-1:0]] <= r_sel;
         r_res_dat_mem[r_res_wp[c_RA_W-1:0]] <= r_dat_w;
      end
   end

   // Head fields read as zero while empty so the storage needs no reset.
   assign res_adr  = res_valid ? r_res_adr_mem[r_res_rp[c_RA_W-1:0]] : '0;
   assign res_sel  = res_valid ? r_res_sel_mem[r_res_rp[c_RA_W-1:0]] : '0;
   assign res_data = res_valid ? r_res_dat_mem[r_res_rp[c_RA_W-1:0]] : '0;

   // ----------------------------------------------------- status counters
   always_ff @(posedge clk) begin
      if (rst) begin
         r_starve   <= 16'd0;
         r_overflow <= 1'b0;
      end else begin
         if (w_rd_resp && w_inst_empty && (r_starve != 16'hFFFF)) begin
            r_starve <= r_starve + 16'd1;
         end
         if (w_res_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign starve_cnt   = r_starve;
   assign res_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_guvm_wb_stim_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_guvm_wb_stim_slave                                        |
// | Description : Self-checking bench for guvm_wb_stim_slave (128-bit bus,     |
// |               depth-8 FIFOs). Directed vector table, hand-written corner   |
// |               sequences, then random traffic against a queue-based model.  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_guvm_wb_stim_slave;

   localparam logic [31:0] NOP = 32'hF0801003;

   logic          clk = 1'b0;
   logic          rst;
   logic          inst_valid;
   logic [31:0]   inst_data;
   logic          inst_ready;
   logic [3:0]    wait_cycles;
   logic          err_inject;
   logic [31:0]   wb_adr;
   logic [15:0]   wb_sel;
   logic          wb_we;
   logic [127:0]  wb_dat_w;
   logic          wb_cyc;
   logic          wb_stb;
   logic [127:0]  wb_dat_r;
   logic          wb_ack;
   logic          wb_err;
   logic          res_valid;
   logic          res_ready;
   logic [127:0]  res_data;
   logic [31:0]   res_adr;
   logic [15:0]   res_sel;
   logic [3:0]    inst_level;
   logic [15:0]   starve_cnt;
   logic          res_overflow;

   guvm_wb_stim_slave dut (
      .clk(clk), .rst(rst),
      .inst_valid(inst_valid), .inst_data(inst_data), .inst_ready(inst_ready),
      .wait_cycles(wait_cycles), .err_inject(err_inject),
      .wb_adr(wb_adr), .wb_sel(wb_sel), .wb_we(wb_we), .wb_dat_w(wb_dat_w),
      .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_dat_r(wb_dat_r),
      .wb_ack(wb_ack), .wb_err(wb_err),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_adr(res_adr), .res_sel(res_sel),
      .inst_level(inst_level), .starve_cnt(starve_cnt), .res_overflow(res_overflow)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Expected read beat: instruction in one lane, NOP elsewhere (lane -1 = all NOP).
   function automatic logic [127:0] lanes(input int lane, input logic [31:0] w);
      logic [127:0] v;
      for (int i = 0; i < 4; i++) v[i*32 +: 32] = (i == lane) ? w : NOP;
      return v;
   endfunction

   task automatic push_word(input logic [31:0] w, output bit acc);
      @(negedge clk);
      acc        = inst_ready;
      inst_valid = 1'b1;
      inst_data  = w;
      @(posedge clk);
      #1;
      inst_valid = 1'b0;
   endtask

   // One bus transfer. lat = number of clock edges from the edge that samples
   // the request to the edge at which the core samples ack/err.
   task automatic xfer(input bit we, input logic [31:0] adr, input logic [15:0] sel,
                       input logic [127:0] dat, input bit er, input int abort_n,
                       output bit ack, output bit err, output logic [127:0] rd, output int lat);
      ack = 1'b0; err = 1'b0; rd = '0; lat = 0;
      @(negedge clk);
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr;
      wb_sel = sel;  wb_dat_w = dat; err_inject = er;
      @(posedge clk);
      for (int n = 1; n <= 40; n++) begin
         #1;
         if (wb_ack || wb_err) begin
            ack = wb_ack; err = wb_err; rd = wb_dat_r; lat = n;
            break;
         end
         if (n == abort_n) break;
         @(posedge clk);
      end
      wb_cyc = 1'b0; wb_stb = 1'b0; err_inject = 1'b0;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit          do_push;
      logic [31:0] push_w;
      logic [31:0] adr;
      logic [3:0]  wt;
      bit          err;
      int          exp_lat;
      bit          chk_data;
      int          exp_lane;
      logic [31:0] exp_word;
      int          exp_lvl;
      int          exp_starve;
   } vec_t;

   typedef struct {
      logic [31:0]  adr;
      logic [15:0]  sel;
      logic [127:0] dat;
   } rec_t;

   vec_t        vt [7];
   logic [31:0] mq [$];
   rec_t        rq [$];
   int          m_starve;
   bit          m_ovf;

   task automatic pop_res(input string tag);
      rec_t r;
      @(negedge clk);
      chk({tag, " res_valid"}, res_valid, rq.size() != 0);
      if (rq.size() != 0) begin
         r = rq.pop_front();
         chk({tag, " res_adr"}, res_adr, r.adr);
         chk({tag, " res_sel"}, res_sel, r.sel);
         chk({tag, " res_data"}, res_data, r.dat);
         res_ready = 1'b1;
         @(posedge clk);
         #1;
         res_ready = 1'b0;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   bit           acc, ack_o, err_o;
   logic [127:0] rd_o;
   int           lat_o, acks;
   rec_t         rr;

   initial begin
      rst = 1'b1; inst_valid = 1'b0; inst_data = '0; wait_cycles = '0; err_inject = 1'b0;
      wb_adr = '0; wb_sel = '0; wb_we = 1'b0; wb_dat_w = '0; wb_cyc = 1'b0; wb_stb = 1'b0;
      res_ready = 1'b0;

      vt[0] = '{1'b0, 32'h0,        32'h00, 4'd0, 1'b0, 1, 1'b1,  0, 32'hE3A01005, 2, 0};
      vt[1] = '{1'b0, 32'h0,        32'h04, 4'd0, 1'b0, 1, 1'b1,  1, 32'hE2812001, 1, 0};
      vt[2] = '{1'b0, 32'h0,        32'h08, 4'd0, 1'b0, 1, 1'b1,  2, 32'hE1A00000, 0, 0};
      vt[3] = '{1'b0, 32'h0,        32'h0C, 4'd2, 1'b0, 3, 1'b1, -1, 32'h0,        0, 1};
      vt[4] = '{1'b1, 32'h12345678, 32'h00, 4'd0, 1'b1, 1, 1'b0, -1, 32'h0,        1, 1};
      vt[5] = '{1'b0, 32'h0,        32'h0C, 4'd1, 1'b0, 2, 1'b1,  3, 32'h12345678, 0, 1};
      vt[6] = '{1'b1, 32'hCAFEF00D, 32'h14, 4'd5, 1'b0, 6, 1'b1,  1, 32'hCAFEF00D, 0, 1};

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset state
      chk("rst inst_ready", inst_ready, 1'b1);
      chk("rst wb_ack", wb_ack, 1'b0);
      chk("rst wb_err", wb_err, 1'b0);
      chk("rst wb_dat_r", wb_dat_r, 128'h0);
      chk("rst res_valid", res_valid, 1'b0);
      chk("rst inst_level", inst_level, 4'd0);
      chk("rst starve_cnt", starve_cnt, 16'd0);
      chk("rst res_overflow", res_overflow, 1'b0);

      // Directed vector table
      push_word(32'hE3A01005, acc);
      push_word(32'hE2812001, acc);
      push_word(32'hE1A00000, acc);
      chk("preload level", inst_level, 4'd3);
      for (int i = 0; i < 7; i++) begin
         if (vt[i].do_push) push_word(vt[i].push_w, acc);
         wait_cycles = vt[i].wt;
         xfer(1'b0, vt[i].adr, 16'hFFFF, '0, vt[i].err, 0, ack_o, err_o, rd_o, lat_o);
         chk($sformatf("vec%0d ack", i), ack_o, !vt[i].err);
         chk($sformatf("vec%0d err", i), err_o, vt[i].err);
         chk($sformatf("vec%0d latency", i), lat_o, vt[i].exp_lat);
         if (vt[i].chk_data)
            chk($sformatf("vec%0d rdata", i), rd_o, lanes(vt[i].exp_lane, vt[i].exp_word));
         chk($sformatf("vec%0d inst_level", i), inst_level, vt[i].exp_lvl);
         chk($sformatf("vec%0d starve_cnt", i), starve_cnt, vt[i].exp_starve);
      end

      // Abort during wait states: no ack, nothing popped
      push_word(32'h0BADF00D, acc);
      wait_cycles = 4'd3;
      xfer(1'b0, 32'h0, 16'hFFFF, '0, 1'b0, 2, ack_o, err_o, rd_o, lat_o);
      acks = int'(ack_o) + int'(err_o);
      for (int c = 0; c < 8; c++) begin
         @(posedge clk);
         #1;
         if (wb_ack || wb_err) acks++;
      end
      chk("abort no response", acks, 0);
      chk("abort inst_level", inst_level, 4'd1);
      wait_cycles = 4'd0;
      xfer(1'b0, 32'h8, 16'hFFFF, '0, 1'b0, 0, ack_o, err_o, rd_o, lat_o);
      chk("post-abort ack", ack_o, 1'b1);
      chk("post-abort rdata", rd_o, lanes(2, 32'h0BADF00D));

      // Fill instruction FIFO past depth, then drain in order
      for (int k = 0; k < 9; k++) begin
         push_word(32'hA0000000 + k, acc);
         chk($sformatf("fill%0d accepted", k), acc, k < 8);
      end
      chk("full inst_level", inst_level, 4'd8);
      chk("full inst_ready", inst_ready, 1'b0);
      for (int k = 0; k < 8; k++) begin
         xfer(1'b0, 32'(k * 4), 16'hFFFF, '0, 1'b0, 0, ack_o, err_o, rd_o, lat_o);
         chk($sformatf("drain%0d rdata", k), rd_o, lanes(k % 4, 32'hA0000000 + k));
      end
      chk("drained inst_level", inst_level, 4'd0);

      // Nine writes with no monitor pops: eight held, one dropped
      for (int k = 0; k < 9; k++) begin
         xfer(1'b1, 32'h100 + 16 * k, 16'hFFFF, 128'(k), 1'b0, 0, ack_o, err_o, rd_o, lat_o);
         chk($sformatf("wr%0d ack", k), ack_o, 1'b1);
         if (k == 7) chk("wr8 no overflow yet", res_overflow, 1'b0);
      end
      chk("wr overflow", res_overflow, 1'b1);
      for (int k = 0; k < 8; k++) begin
         rr.adr = 32'h100 + 16 * k; rr.sel = 16'hFFFF; rr.dat = 128'(k);
         rq.push_back(rr);
         pop_res($sformatf("wrpop%0d", k));
      end
      @(negedge clk);
      chk("wr res empty", res_valid, 1'b0);

      // Reset during wait states, then a request in the first cycle after reset
      push_word(32'h11111111, acc);
      push_word(32'h22222222, acc);
      wait_cycles = 4'd5;
      @(negedge clk);
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h0; err_inject = 1'b0;
      acks = 0;
      repeat (2) begin
         @(posedge clk);
         #1;
         if (wb_ack || wb_err) acks++;
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      if (wb_ack || wb_err) acks++;
      @(negedge clk);
      rst = 1'b0;
      wait_cycles = 4'd0;
      chk("rstwait no response", acks, 0);
      chk("rstwait inst_level", inst_level, 4'd0);
      chk("rstwait inst_ready", inst_ready, 1'b1);
      chk("rstwait res_valid", res_valid, 1'b0);
      chk("rstwait res_overflow", res_overflow, 1'b0);
      @(posedge clk);
      #1;
      chk("rstwait new req ack", wb_ack, 1'b1);
      chk("rstwait new req rdata", wb_dat_r, lanes(-1, 32'h0));
      wb_cyc = 1'b0; wb_stb = 1'b0;
      @(posedge clk);
      #1;
      chk("rstwait starve_cnt", starve_cnt, 16'd1);

      // Random traffic against the queue model
      mq.delete(); rq.delete(); m_starve = 1; m_ovf = 1'b0;
      for (int it = 0; it < 150; it++) begin
         int           np;
         bit           we, er;
         logic [31:0]  w, adr;
         logic [15:0]  sel;
         logic [127:0] dat, exp_rd;
         logic [3:0]   wt;
         np = $urandom_range(0, 3);
         for (int p = 0; p < np; p++) begin
            w = $urandom;
            push_word(w, acc);
            chk("rnd push accept", acc, mq.size() < 8);
            if (mq.size() < 8) mq.push_back(w);
         end
         we = ($urandom_range(0, 1) == 1);
         er = ($urandom_range(0, 7) == 0);
         adr = $urandom; sel = 16'($urandom);
         dat = {$urandom, $urandom, $urandom, $urandom};
         wt = 4'($urandom_range(0, 3));
         wait_cycles = wt;
         xfer(we, adr, sel, dat, er, 0, ack_o, err_o, rd_o, lat_o);
         chk("rnd ack", ack_o, !er);
         chk("rnd err", err_o, er);
         chk("rnd latency", lat_o, int'(wt) + 1);
         if (!er && !we) begin
            if (mq.size() != 0) begin
               exp_rd = lanes(int'(adr[3:2]), mq.pop_front());
            end else begin
               exp_rd = lanes(-1, 32'h0);
               m_starve++;
            end
            chk("rnd rdata", rd_o, exp_rd);
         end
         if (!er && we) begin
            if (rq.size() < 8) begin
               rr.adr = adr; rr.sel = sel; rr.dat = dat;
               rq.push_back(rr);
            end else begin
               m_ovf = 1'b1;
            end
         end
         chk("rnd inst_level", inst_level, mq.size());
         chk("rnd starve_cnt", starve_cnt, m_starve);
         chk("rnd res_overflow", res_overflow, m_ovf);
         if ($urandom_range(0, 2) == 0) pop_res("rnd");
      end
      while (rq.size() != 0) pop_res("final");
      pop_res("final empty");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
